// File: rtl/obstacle_field_gen.sv
// obstacle_field_gen
//
// Scrolling ROWS x COLS obstacle bitmap for the 160x120 Flappy renderer.
// Every accepted step shifts the field one column to the left and inserts a
// freshly generated column on the right. A column is either part of a pipe
// (solid except for a GAP_ROWS-high opening) or empty. The gap position
// comes from a 16-bit Galois LFSR (tap mask 16'hB400) that only advances
// on accepted steps, so the obstacle sequence is repeatable after reset.
//
// Optional feature macro: COLLISION_EN
//   defined     -> hit is a registered lookup of field[bird_row][bird_col]
//   not defined -> hit is tied low and no collision logic is built
//   The port list is the same in both builds.
//
// Ports:
//   CLOCK_50      in   system clock
//   resetn        in   synchronous, active-low reset
//   enable        in   allows step requests to be accepted
//   step          in   scroll request, level-sampled while idle
//   rd_row        in   read row address
//   rd_col        in   read column address (0 = leftmost)
//   rd_bit        out  registered field[rd_row][rd_col], 0 when out of range
//   busy          out  high while a step is being processed
//   step_done     out  1-cycle pulse on the edge the field is updated
//   pipe_passed   out  1-cycle pulse with step_done when the dropped column held a 1
//   step_overrun  out  1-cycle pulse when a step is requested while busy
//   bird_row      in   collision query row    (COLLISION_EN only)
//   bird_col      in   collision query column (COLLISION_EN only)
//   hit           out  registered collision flag

module obstacle_field_gen #(
  parameter int          ROWS         = 30,
  parameter int          COLS         = 40,
  parameter int          GAP_ROWS     = 8,
  parameter int          PIPE_SPACING = 10,
  parameter int          PIPE_WIDTH   = 2,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                     CLOCK_50,
  input  logic                     resetn,
  input  logic                     enable,
  input  logic                     step,
  input  logic [$clog2(ROWS)-1:0]  rd_row,
  input  logic [$clog2(COLS)-1:0]  rd_col,
  output logic                     rd_bit,
  output logic                     busy,
  output logic                     step_done,
  output logic                     pipe_passed,
  output logic                     step_overrun,
  input  logic [$clog2(ROWS)-1:0]  bird_row,
  input  logic [$clog2(COLS)-1:0]  bird_col,
  output logic                     hit
);

  localparam int RW    = $clog2(ROWS);
  localparam int SW    = (PIPE_SPACING > 1) ? $clog2(PIPE_SPACING) : 1;
  // Number of legal gap start positions; gap_top ends up in 1..RANGE so the
  // pipe always keeps at least one solid row above and below the opening.
  localparam int RANGE = ROWS - GAP_ROWS - 1;

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    SHIFT
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [ROWS-1:0]   field [COLS];
  logic [15:0]       lfsr;
  logic [15:0]       lfsr_next;
  logic [7:0]        raw;
  logic [RW-1:0]     gap_top;
  logic [SW-1:0]     spacing_cnt;
  logic [ROWS-1:0]   new_col;
  int                gap_lo;

  logic              raw_ge_range;
  logic              pipe_slot;
  logic              rd_in_range;

  logic              accept;
  logic              gen_sub;
  logic              gen_done;
  logic              do_shift;
  logic              overrun_req;

  // Right-shifting Galois LFSR: the bit falling out of position 0 folds the
  // tap mask back into the register.
  assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);

  // raw is reduced modulo RANGE by repeated subtraction, one per GEN cycle.
  assign raw_ge_range = (32'(raw) >= RANGE);

  // The first PIPE_WIDTH slots of every spacing period are pipe columns.
  assign pipe_slot    = (32'(spacing_cnt) < PIPE_WIDTH);
  assign gap_lo       = 32'(gap_top);
  assign rd_in_range  = (32'(rd_row) < ROWS) && (32'(rd_col) < COLS);

  // Column that enters on the right: solid pipe with an opening of GAP_ROWS
  // rows starting at gap_top, or all zeros outside the pipe slots.
  always_comb begin
    new_col = '0;
    for (int r = 0; r < ROWS; r++) begin
      new_col[r] = pipe_slot && ((r < gap_lo) || (r >= gap_lo + GAP_ROWS));
    end
  end

  // State register.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Only the first column of a pipe period needs a new
  // gap, so only those steps pass through GEN.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (step && enable) begin
          state_next = (spacing_cnt == '0) ? GEN : SHIFT;
        end
      end
      GEN: begin
        if (!raw_ge_range) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output / control strobes decoded from the current state.
  always_comb begin
    busy        = (state != IDLE);
    accept      = (state == IDLE) && step && enable;
    gen_sub     = (state == GEN) && raw_ge_range;
    gen_done    = (state == GEN) && !raw_ge_range;
    do_shift    = (state == SHIFT);
    overrun_req = (state != IDLE) && step && enable;
  end

  // Datapath: LFSR, gap generation, field shift and the registered read port.
  // Requests that arrive while busy only raise step_overrun; nothing else moves.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      for (int c = 0; c < COLS; c++) begin
        field[c] <= '0;
      end
      lfsr         <= LFSR_SEED;
      raw          <= '0;
      gap_top      <= '0;
      spacing_cnt  <= '0;
      rd_bit       <= 1'b0;
      step_done    <= 1'b0;
      pipe_passed  <= 1'b0;
      step_overrun <= 1'b0;
    end else begin
      if (accept) begin
        raw  <= lfsr[7:0];
        lfsr <= lfsr_next;
      end else if (gen_sub) begin
        raw <= raw - 8'(RANGE);
      end

      if (gen_done) begin
        gap_top <= RW'(32'(raw) + 1);
      end

      if (do_shift) begin
        for (int c = 0; c < COLS - 1; c++) begin
          field[c] <= field[c+1];
        end
        field[COLS-1] <= new_col;
        spacing_cnt   <= (32'(spacing_cnt) == PIPE_SPACING - 1) ? '0 : spacing_cnt + 1'b1;
      end

      step_done    <= do_shift;
      pipe_passed  <= do_shift && (|field[0]);
      step_overrun <= overrun_req;

      // Reads see the pre-shift contents when sampled on the shift edge.
      rd_bit <= rd_in_range ? field[rd_col][rd_row] : 1'b0;
    end
  end

`ifdef COLLISION_EN
  logic bird_in_range;

  assign bird_in_range = (32'(bird_row) < ROWS) && (32'(bird_col) < COLS);

  // Collision lookup, same timing and range handling as the read port.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      hit <= 1'b0;
    end else begin
      hit <= bird_in_range ? field[bird_col][bird_row] : 1'b0;
    end
  end
`else
  logic unused_bird;

  assign unused_bird = ^{bird_row, bird_col};
  assign hit         = 1'b0;
`endif

endmodule

// File: tb/tb_obstacle_field_gen.sv
// tb_obstacle_field_gen
//
// Self-checking bench for obstacle_field_gen with default parameters.
// A behavioural model keeps the field as a plain 2-D bit array, derives each
// gap with a modulo/divide of the LFSR byte and predicts step latency from
// the quotient. Stimulus mixes fixed scenarios with randomized idle gaps and
// random read addresses (including out-of-range ones).

module tb_obstacle_field_gen;

  localparam int ROWS         = 30;
  localparam int COLS         = 40;
  localparam int GAP_ROWS     = 8;
  localparam int PIPE_SPACING = 10;
  localparam int PIPE_WIDTH   = 2;
  localparam int RW           = $clog2(ROWS);
  localparam int CW           = $clog2(COLS);
  localparam int RANGE        = ROWS - GAP_ROWS - 1;

  logic          CLOCK_50;
  logic          resetn;
  logic          enable;
  logic          step;
  logic [RW-1:0] rd_row;
  logic [CW-1:0] rd_col;
  logic          rd_bit;
  logic          busy;
  logic          step_done;
  logic          pipe_passed;
  logic          step_overrun;
  logic [RW-1:0] bird_row;
  logic [CW-1:0] bird_col;
  logic          hit;

  int compared;
  int mismatched;

  // Reference model state
  bit          mfield [COLS][ROWS];
  logic [15:0] mlfsr;
  int          msp;
  int          mgap;

  obstacle_field_gen dut (
    .CLOCK_50     (CLOCK_50),
    .resetn       (resetn),
    .enable       (enable),
    .step         (step),
    .rd_row       (rd_row),
    .rd_col       (rd_col),
    .rd_bit       (rd_bit),
    .busy         (busy),
    .step_done    (step_done),
    .pipe_passed  (pipe_passed),
    .step_overrun (step_overrun),
    .bird_row     (bird_row),
    .bird_col     (bird_col),
    .hit          (hit)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  // Hard stop in case a wait escapes its bound.
  initial begin
    #4ms;
    $display("[TB] FAIL watchdog: simulation did not finish (got timeout, expected completion)");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  task automatic model_reset;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        mfield[c][r] = 1'b0;
    mlfsr = 16'hACE1;
    msp   = 0;
    mgap  = 0;
  endtask

  // One accepted step: predicted latency (edges after acceptance) and
  // whether the dropped column held an obstacle.
  task automatic model_step(output int lat, output bit passed);
    int raw;
    raw   = int'(mlfsr[7:0]);
    mlfsr = lfsr_adv(mlfsr);
    if (msp == 0) begin
      mgap = raw % RANGE + 1;
      lat  = raw / RANGE + 2;
    end else begin
      lat = 1;
    end
    passed = 1'b0;
    for (int r = 0; r < ROWS; r++)
      if (mfield[0][r]) passed = 1'b1;
    for (int c = 0; c < COLS - 1; c++)
      for (int r = 0; r < ROWS; r++)
        mfield[c][r] = mfield[c+1][r];
    for (int r = 0; r < ROWS; r++)
      mfield[COLS-1][r] = (msp < PIPE_WIDTH) && !(r >= mgap && r < mgap + GAP_ROWS);
    msp = (msp + 1) % PIPE_SPACING;
  endtask

  task automatic tick;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic read_bit(input int row, input int col, output logic v);
    rd_row = RW'(row);
    rd_col = CW'(col);
    tick;
    v = rd_bit;
  endtask

  task automatic do_reset;
    resetn = 1'b0;
    step   = 1'b0;
    enable = 1'b1;
    tick;
    tick;
    resetn = 1'b1;
    model_reset();
  endtask

  // Issue one step, optionally holding step high for 'hold_req' busy edges
  // to provoke overruns, and check latency, pipe_passed and the idle return.
  task automatic run_step(input int hold_req, input string name, output logic dut_passed);
    int   lat;
    int   k;
    int   hold;
    bit   exp_passed;
    bit   got;
    model_step(lat, exp_passed);
    hold = (hold_req > lat) ? lat : hold_req;
    step = 1'b1;
    tick;
    if (hold == 0) step = 1'b0;
    got = 0;
    k = 0;
    dut_passed = 1'b0;
    while (!got && k < 400) begin
      tick;
      k++;
      if (k <= hold) begin
        compared++;
        if (step_overrun !== 1'b1) begin
          mismatched++;
          $display("[TB] FAIL %s_overrun edge %0d: got %b expected 1", name, k, step_overrun);
        end
      end
      if (k == hold) step = 1'b0;
      if (step_done === 1'b1) begin
        got = 1;
        dut_passed = pipe_passed;
      end
    end
    compared++;
    if (!got || k != lat) begin
      mismatched++;
      $display("[TB] FAIL %s_latency: got %0d edges (done=%0d) expected %0d", name, k, got, lat);
    end
    compared++;
    if (dut_passed !== exp_passed) begin
      mismatched++;
      $display("[TB] FAIL %s_pipe_passed: got %b expected %b", name, dut_passed, exp_passed);
    end
    tick;
    compared++;
    if ({busy, step_done, step_overrun} !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL %s_after: got busy/done/ovr=%b expected 000", name,
               {busy, step_done, step_overrun});
    end
  endtask

  task automatic test_reset;
    logic v;
    resetn   = 1'b0;
    step     = 1'b0;
    enable   = 1'b1;
    rd_row   = '0;
    rd_col   = '0;
    bird_row = '0;
    bird_col = '0;
    tick;
    tick;
    compared++;
    if ({busy, step_done, pipe_passed, step_overrun, hit, rd_bit} !== 6'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got %b expected 000000",
               {busy, step_done, pipe_passed, step_overrun, hit, rd_bit});
    end
    resetn = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      int r;
      int c;
      r = $urandom_range(0, ROWS - 1);
      c = $urandom_range(0, COLS - 1);
      read_bit(r, c, v);
      compared++;
      if (v !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL reset_field[%0d][%0d]: got %b expected 0", r, c, v);
      end
    end
  endtask

  task automatic test_first_step;
    logic p;
    logic v;
    logic exp_hit;
    int   errs;
    run_step(0, "step1", p);
    errs = 0;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++) begin
        read_bit(r, c, v);
        compared++;
        if (v !== mfield[c][r]) begin
          mismatched++;
          errs++;
          if (errs < 5)
            $display("[TB] FAIL step1_field[%0d][%0d]: got %b expected %b", r, c, v, mfield[c][r]);
        end
      end
    // Gap row 20 in column 39 must read open one cycle after addressing it.
    rd_row = RW'(20);
    rd_col = CW'(39);
    tick;
    compared++;
    if (rd_bit !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL read_latency_gap: got %b expected 0", rd_bit);
    end
    rd_row = RW'(5);
    tick;
    compared++;
    if (rd_bit !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL read_latency_solid: got %b expected 1", rd_bit);
    end
    bird_row = RW'(5);
    bird_col = CW'(39);
    tick;
`ifdef COLLISION_EN
    exp_hit = mfield[39][5];
`else
    exp_hit = 1'b0;
`endif
    compared++;
    if (hit !== exp_hit) begin
      mismatched++;
      $display("[TB] FAIL hit_solid: got %b expected %b", hit, exp_hit);
    end
    bird_col = CW'(50);
    tick;
    compared++;
    if (hit !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL hit_out_of_range: got %b expected 0", hit);
    end
    bird_col = '0;
  endtask

  task automatic test_second_step;
    logic p;
    logic v;
    run_step(0, "step2", p);
    for (int c = COLS - 2; c < COLS; c++)
      for (int r = 0; r < ROWS; r++) begin
        read_bit(r, c, v);
        compared++;
        if (v !== mfield[c][r]) begin
          mismatched++;
          $display("[TB] FAIL step2_field[%0d][%0d]: got %b expected %b", r, c, v, mfield[c][r]);
        end
      end
  endtask

  task automatic test_random_steps;
    logic p;
    logic v;
    logic exp;
    int   gap;
    int   r;
    int   c;
    int   errs;
    int   passed_list[$];
    for (int n = 3; n <= 60; n++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        r = $urandom_range(0, 31);
        c = $urandom_range(0, 63);
        read_bit(r, c, v);
        exp = (r < ROWS && c < COLS) ? mfield[c][r] : 1'b0;
        compared++;
        if (v !== exp) begin
          mismatched++;
          $display("[TB] FAIL rand_read[%0d][%0d]: got %b expected %b", r, c, v, exp);
        end
      end
      run_step(0, "rand", p);
      if (p === 1'b1) passed_list.push_back(n);
      if (n == 11) begin
        for (int cc = COLS - 12; cc < COLS; cc++)
          for (int rr = 0; rr < ROWS; rr++) begin
            read_bit(rr, cc, v);
            compared++;
            if (v !== mfield[cc][rr]) begin
              mismatched++;
              $display("[TB] FAIL step11_field[%0d][%0d]: got %b expected %b", rr, cc, v, mfield[cc][rr]);
            end
          end
      end
    end
    compared++;
    if (passed_list.size() != 4 || passed_list[0] != 41 || passed_list[1] != 42 ||
        passed_list[2] != 51 || passed_list[3] != 52) begin
      mismatched++;
      $display("[TB] FAIL pipe_passed_steps: got %p expected '{41,42,51,52}", passed_list);
    end
    errs = 0;
    for (int cc = 0; cc < COLS; cc++)
      for (int rr = 0; rr < ROWS; rr++) begin
        read_bit(rr, cc, v);
        compared++;
        if (v !== mfield[cc][rr]) begin
          mismatched++;
          errs++;
          if (errs < 5)
            $display("[TB] FAIL rand_field[%0d][%0d]: got %b expected %b", rr, cc, v, mfield[cc][rr]);
        end
      end
  endtask

  task automatic test_overrun;
    logic p;
    logic v;
    run_step(3, "ovr_gen", p);
    run_step(3, "ovr_shift", p);
    for (int c = COLS - 4; c < COLS; c++)
      for (int r = 0; r < ROWS; r++) begin
        read_bit(r, c, v);
        compared++;
        if (v !== mfield[c][r]) begin
          mismatched++;
          $display("[TB] FAIL ovr_field[%0d][%0d]: got %b expected %b", r, c, v, mfield[c][r]);
        end
      end
  endtask

  task automatic test_enable_low;
    logic v;
    enable = 1'b0;
    step   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      compared++;
      if ({busy, step_done, step_overrun} !== 3'b000) begin
        mismatched++;
        $display("[TB] FAIL enable_low cycle %0d: got busy/done/ovr=%b expected 000", i,
                 {busy, step_done, step_overrun});
      end
    end
    step   = 1'b0;
    enable = 1'b1;
    for (int r = 0; r < ROWS; r++) begin
      read_bit(r, COLS - 1, v);
      compared++;
      if (v !== mfield[COLS-1][r]) begin
        mismatched++;
        $display("[TB] FAIL enable_low_field[%0d]: got %b expected %b", r, v, mfield[COLS-1][r]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    int k;
    bit ep;
    bit got;
    step = 1'b1;
    for (int n = 0; n < 20; n++) begin
      model_step(lat, ep);
      tick;
      compared++;
      if (busy !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL b2b_accept %0d: got busy=%b expected 1", n, busy);
      end
      k = 0;
      got = 0;
      while (!got && k < 400) begin
        tick;
        k++;
        if (step_done === 1'b1) got = 1;
      end
      if (n == 19) step = 1'b0;
      compared++;
      if (!got || k != lat) begin
        mismatched++;
        $display("[TB] FAIL b2b_latency %0d: got %0d expected %0d", n, k, lat);
      end
      compared++;
      if (pipe_passed !== ep) begin
        mismatched++;
        $display("[TB] FAIL b2b_pipe_passed %0d: got %b expected %b", n, pipe_passed, ep);
      end
    end
    tick;
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL b2b_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid_gen;
    logic p;
    logic v;
    do_reset();
    for (int n = 1; n <= 10; n++) run_step(0, "mg_pre", p);
    // Step 11 starts a pipe, so the FSM is inside GEN one edge after acceptance.
    step = 1'b1;
    tick;
    step = 1'b0;
    tick;
    resetn = 1'b0;
    tick;
    compared++;
    if ({busy, step_done, pipe_passed, step_overrun, hit, rd_bit} !== 6'b0) begin
      mismatched++;
      $display("[TB] FAIL midgen_outputs: got %b expected 000000",
               {busy, step_done, pipe_passed, step_overrun, hit, rd_bit});
    end
    resetn = 1'b1;
    model_reset();
    for (int c = COLS - 10; c < COLS; c++)
      for (int r = 0; r < ROWS; r++) begin
        read_bit(r, c, v);
        compared++;
        if (v !== 1'b0) begin
          mismatched++;
          $display("[TB] FAIL midgen_field[%0d][%0d]: got %b expected 0", r, c, v);
        end
      end
    run_step(0, "midgen_restart", p);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_first_step();
    test_second_step();
    test_random_steps();
    test_overrun();
    test_enable_low();
    test_back_to_back();
    test_reset_mid_gen();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/obstacle_field_gen.md
Name: obstacle_field_gen

Overview:
Parametrised successor to the fixed 30x40-bit obstacle shift-register bank. Holds a ROWS x COLS scrolling obstacle bitmap for the 160x120 Flappy renderer. Each accepted step shifts the field one column left and inserts a generated column on the right: either a pipe with a pseudo-random gap, or an empty column. Provides a registered random-access read port for the VGA draw FSM, plus score and overrun pulses.

Parameters:
ROWS, 30, field height in rows (minimum GAP_ROWS+2)
COLS, 40, field width in columns
GAP_ROWS, 8, height of the open gap in a pipe column
PIPE_SPACING, 10, columns per pipe period (pipe plus space)
PIPE_WIDTH, 2, pipe columns per period (1..PIPE_SPACING-1)
LFSR_SEED, 16'hACE1, LFSR reset value (must be nonzero)

Ports:
CLOCK_50  in  1  system clock
resetn  in  1  synchronous active-low reset
enable  in  1  step acceptance enable
step  in  1  request one scroll step (level sampled in IDLE)
rd_row  in  clog2(ROWS)  read row address
rd_col  in  clog2(COLS)  read column address (0 = leftmost)
rd_bit  out  1  field[rd_row][rd_col], registered
busy  out  1  high when state != IDLE
step_done  out  1  1-cycle pulse when the field update has occurred
pipe_passed  out  1  1-cycle pulse, concurrent with step_done, when the discarded column 0 held any 1
step_overrun  out  1  1-cycle pulse when step=1 and enable=1 while busy
bird_row  in  clog2(ROWS)  collision query row (used only with COLLISION_EN)
bird_col  in  clog2(COLS)  collision query column (used only with COLLISION_EN)
hit  out  1  collision flag

Behaviour:
- Reset is synchronous on CLOCK_50 with resetn low:
  - field all 0, lfsr=LFSR_SEED, spacing_cnt=0, gap_top=0, state IDLE.
  - rd_bit, step_done, pipe_passed, step_overrun and hit are 0.
  - Reset mid-operation aborts immediately; no partial shift.
- The LFSR is a 16-bit Galois LFSR with tap mask 16'hB400. It advances only on accepted steps.
- FSM:
  - IDLE: step&enable accepts the step. On acceptance: raw<=lfsr[7:0] (pre-advance value) and the LFSR advances. Next state is GEN if spacing_cnt==0, else SHIFT. With enable low, step is ignored.
  - GEN: RANGE=ROWS-GAP_ROWS-1.
    - If raw>=RANGE: raw<=raw-RANGE, stay in GEN.
    - Else: gap_top<=raw+1, go to SHIFT.
    - Takes at most ceil(256/RANGE)+1 cycles.
  - SHIFT: col[c]<=col[c+1] for c<COLS-1; col[COLS-1]<=new column.
    - spacing_cnt increments and wraps from PIPE_SPACING-1 to 0.
    - step_done<=1; pipe_passed<=|old col[0]. Return to IDLE.
- New column: if spacing_cnt (pre-increment) < PIPE_WIDTH, it is a pipe column: row r = 0 when gap_top <= r < gap_top+GAP_ROWS, else 1. Otherwise all 0. All PIPE_WIDTH columns of one pipe reuse the same gap_top.
- Step latency:
  - Non-pipe-start step: field update and step_done on edge 1 after the accepting edge.
  - Pipe-start step: edge 1 + n_sub + 1, where n_sub is the number of GEN subtractions.
- Read port:
  - rd_bit<=field[rd_row][rd_col] every cycle, 1-cycle latency.
  - Out-of-range address returns 0.
  - A read sampled on the SHIFT edge returns the pre-shift value.
- step_overrun: the request is dropped and no state changes.
- A step held high in IDLE is re-accepted every time the FSM returns to IDLE.

Optional Feature:
COLLISION_EN
- Defined: hit<=field[bird_row][bird_col] every cycle, 1-cycle latency, 0 when out of range.
- Not defined: hit is tied to 0, bird_row and bird_col are unused, and no collision logic is built.
- The port list is identical in both builds.

Test Plan:
- Reset, then a single step pulse with enable=1 (defaults) -> raw=0xE1=225, 10 subtractions, gap_top=16, step_done 12 edges after acceptance; col 39 reads 1 at rows 0-15 and 24-29, 0 at rows 16-23; cols 0-38 read 0.
- Second step -> step_done 1 edge after acceptance; cols 38 and 39 both hold the gap-16 pattern.
- Steps 3 through 10 -> empty columns inserted; step 11 -> GEN re-entered with the advanced LFSR; the gap lies within rows 1..28-GAP_ROWS+1.
- Continuous steps from reset -> pipe_passed pulses exactly on steps 41 and 42, then every 10 steps in pairs.
- step asserted while busy -> step_overrun pulses and the field is unchanged; enable=0 with step=1 -> no acceptance and busy stays 0; resetn low during GEN -> field and outputs return to 0 next edge.
- Read latency: rd_row=20, rd_col=39 after step 1 -> rd_bit=0 one cycle later. With COLLISION_EN: bird_row=5, bird_col=39 -> hit=1 one cycle later.
